// File: rtl/dmem_ctrl.sv
// Data-RAM arbiter: shares a single-port 1024x32 RAM between CPU load/store
// requests and a periodic display-scan reader, with fair alternation on ties.
//
// state  | meaning
// IDLE   | arbitrate between CPU request and pending scan line
// C_ACC  | CPU address/data presented, RAM samples this cycle
// C_DONE | capture RAM read data, pulse cpu_ack
// S_ACC  | scan line address presented, RAM samples this cycle
// S_DONE | capture line data, pulse disp_valid, advance line counter
module dmem_ctrl #(
  parameter int LINES    = 16,
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        scan_en,
  output logic        scan_busy,
  output logic [3:0]  disp_line,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam int RW = $clog2(SCAN_DIV);
  localparam logic [RW-1:0] REF_MAX   = RW'(SCAN_DIV - 1);
  localparam logic [3:0]    LAST_LINE = 4'(LINES - 1);
  localparam logic          GRANT_CPU  = 1'b0;
  localparam logic          GRANT_SCAN = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    C_ACC  = 3'd1,
    C_DONE = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [3:0]    line_cnt_q, line_cnt_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          scan_pending_q, scan_pending_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [3:0]    disp_line_q, disp_line_d;
  logic [31:0]   disp_data_q, disp_data_d;
  logic          disp_valid_q, disp_valid_d;
  logic [9:0]    ram_addr_q, ram_addr_d;
  logic          ram_we_q, ram_we_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;

  logic cpu_want;
  logic scan_want;
  logic ref_wrap;

  // Byte offset and bits above 4 KiB are intentionally discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:12], cpu_addr[1:0]};

  assign cpu_want  = cpu_req && !cpu_ack_q;
  assign scan_want = scan_pending_q;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    line_cnt_d     = line_cnt_q;
    ref_cnt_d      = ref_cnt_q;
    scan_pending_d = scan_pending_q;
    cpu_rdata_d    = cpu_rdata_q;
    cpu_ack_d      = 1'b0;
    disp_line_d    = disp_line_q;
    disp_data_d    = disp_data_q;
    disp_valid_d   = 1'b0;
    ram_addr_d     = ram_addr_q;
    ram_we_d       = ram_we_q;
    ram_wdata_d    = ram_wdata_q;
    ref_wrap       = 1'b0;

    if (!scan_en) begin
      ref_cnt_d = '0;
    end else if (ref_cnt_q == REF_MAX) begin
      ref_cnt_d = '0;
      ref_wrap  = 1'b1;
    end else begin
      ref_cnt_d = ref_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cpu_want && (!scan_want || last_grant_q == GRANT_SCAN)) begin
          ram_addr_d   = cpu_addr[11:2];
          ram_we_d     = cpu_we;
          ram_wdata_d  = cpu_wdata;
          last_grant_d = GRANT_CPU;
          state_d      = C_ACC;
        end else if (scan_want) begin
          ram_addr_d   = {6'b0, line_cnt_q};
          ram_we_d     = 1'b0;
          last_grant_d = GRANT_SCAN;
          state_d      = S_ACC;
        end
      end
      C_ACC: begin
        ram_we_d = 1'b0;
        state_d  = C_DONE;
      end
      C_DONE: begin
        cpu_rdata_d = ram_rdata;
        cpu_ack_d   = 1'b1;
        state_d     = IDLE;
      end
      S_ACC: begin
        ram_we_d = 1'b0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        disp_data_d  = ram_rdata;
        disp_line_d  = line_cnt_q;
        disp_valid_d = 1'b1;
        state_d      = IDLE;
        if (line_cnt_q == LAST_LINE) begin
          line_cnt_d     = '0;
          scan_pending_d = 1'b0;
        end else begin
          line_cnt_d = line_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        ram_we_d = 1'b0;
      end
    endcase

    // A tick arriving while a scan is still owed is dropped, not queued.
    if (ref_wrap && !scan_pending_q) begin
      scan_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= GRANT_SCAN;
      line_cnt_q     <= '0;
      ref_cnt_q      <= '0;
      scan_pending_q <= 1'b0;
      cpu_rdata_q    <= '0;
      cpu_ack_q      <= 1'b0;
      disp_line_q    <= '0;
      disp_data_q    <= '0;
      disp_valid_q   <= 1'b0;
      ram_addr_q     <= '0;
      ram_we_q       <= 1'b0;
      ram_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      line_cnt_q     <= line_cnt_d;
      ref_cnt_q      <= ref_cnt_d;
      scan_pending_q <= scan_pending_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_ack_q      <= cpu_ack_d;
      disp_line_q    <= disp_line_d;
      disp_data_q    <= disp_data_d;
      disp_valid_q   <= disp_valid_d;
      ram_addr_q     <= ram_addr_d;
      ram_we_q       <= ram_we_d;
      ram_wdata_q    <= ram_wdata_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign scan_busy  = scan_pending_q;
  assign disp_line  = disp_line_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: CPU access vector table plus scan, contention and
// mid-access reset sequences against a behavioural synchronous RAM.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        scan_en = 1'b0;
  logic        scan_busy;
  logic [3:0]  disp_line;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  dmem_ctrl #(.LINES(16), .SCAN_DIV(20)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .scan_en(scan_en), .scan_busy(scan_busy),
    .disp_line(disp_line), .disp_data(disp_data), .disp_valid(disp_valid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word k holds k+0x100 after any reset; read-during-write returns old data.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 32'(k) + 32'h100;
      ram_rdata <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'h0);
    check({tag, "_disp_line"}, 32'(disp_line), 32'h0);
    check({tag, "_disp_data"}, disp_data, 32'h0);
    check({tag, "_disp_valid"}, 32'(disp_valid), 32'h0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'h0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    check({tag, "_scan_busy"}, 32'(scan_busy), 32'h0);
  endtask

  // Uncontended access: grant on the first edge, ack visible after the third.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [9:0] exp_addr, input logic [31:0] exp_rdata,
                            input string tag);
    int  n;
    logic got;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 12) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'(exp_addr));
        check({tag, "_ram_we_on"}, 32'(ram_we), 32'(we));
        if (we) check({tag, "_ram_wdata"}, ram_wdata, wdata);
      end
      if (n == 2) check({tag, "_ram_we_off"}, 32'(ram_we), 32'h0);
      if (cpu_ack) got = 1'b1;
    end
    cpu_req = 1'b0;
    check({tag, "_ack_latency"}, 32'(n), 32'd3);
    if (got && !we) check({tag, "_rdata"}, cpu_rdata, exp_rdata);
    @(posedge clk); #1;
    check({tag, "_ack_drop"}, 32'(cpu_ack), 32'h0);
  endtask

  task automatic wait_line(input int bound, input logic [3:0] exp_line, input string tag,
                           output int when);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!disp_valid && n < bound);
    check({tag, "_seen"}, 32'(disp_valid), 32'h1);
    check({tag, "_line"}, 32'(disp_line), 32'(exp_line));
    check({tag, "_data"}, disp_data, 32'h100 + 32'(exp_line));
    when = cyc;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [9:0]  exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t, tprev, lines, acks_between, last_ack, extra;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 10'd4,     32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         10'd4,     32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_1008, 32'h0,         10'd2,     32'h0000_0102};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 10'h3FF,   32'h0};
    vecs[4] = '{1'b0, 32'h0000_0FFF, 32'h0,         10'h3FF,   32'h1234_5678};
    vecs[5] = '{1'b1, 32'h0000_0013, 32'h0000_0104, 10'd4,     32'h0};
    vecs[6] = '{1'b0, 32'h0000_0010, 32'h0,         10'd4,     32'h0000_0104};

    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 7; i++) cpu_access(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                                            vecs[i].exp_addr, vecs[i].exp_rdata,
                                            $sformatf("vec%0d", i));

    // Scan only: first tick 20 edges after enable, lines 3 apart, later ticks dropped.
    scan_en = 1'b1; t0 = cyc;
    check("scan_busy_idle", 32'(scan_busy), 32'h0);
    wait_line(40, 4'd0, "scan1_l0", t);
    check("scan1_first_time", 32'(t - t0), 32'd23);
    check("scan1_busy", 32'(scan_busy), 32'h1);
    tprev = t;
    for (int k = 1; k < 16; k++) begin
      wait_line(10, 4'(k), $sformatf("scan1_l%0d", k), t);
      check($sformatf("scan1_gap%0d", k), 32'(t - tprev), 32'd3);
      tprev = t;
    end
    check("scan1_busy_end", 32'(scan_busy), 32'h0);
    wait_line(40, 4'd0, "scan2_l0", t);
    check("scan2_start_time", 32'(t - t0), 32'd83);

    // Disabling mid-scan still lets the remaining lines finish.
    scan_en = 1'b0; tprev = t;
    for (int k = 1; k < 16; k++) begin
      wait_line(10, 4'(k), $sformatf("scan2_l%0d", k), t);
      check($sformatf("scan2_gap%0d", k), 32'(t - tprev), 32'd3);
      tprev = t;
    end
    extra = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (disp_valid) extra++;
    end
    check("scan_disabled_quiet", 32'(extra), 32'h0);
    check("scan_disabled_busy", 32'(scan_busy), 32'h0);

    // Contention: continuous CPU reads of word 8 during a scan.
    cpu_we = 1'b0; cpu_addr = 32'h0000_0020; cpu_req = 1'b1; scan_en = 1'b1;
    lines = 0; acks_between = 0; last_ack = -1; tprev = 0;
    for (int n = 0; n < 400 && lines < 16; n++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin
        check("cont_rdata", cpu_rdata, 32'h0000_0108);
        if (last_ack >= 0) check("cont_ack_gap_le7", 32'((cyc - last_ack) <= 7), 32'h1);
        last_ack = cyc;
        acks_between++;
      end
      if (disp_valid) begin
        check("cont_line", 32'(disp_line), 32'(lines));
        check("cont_data", disp_data, 32'h100 + 32'(lines));
        if (lines > 0) begin
          check("cont_line_gap_le7", 32'((cyc - tprev) <= 7), 32'h1);
          check("cont_alternate", 32'(acks_between), 32'h1);
        end
        tprev = cyc; acks_between = 0; lines++;
        scan_en = 1'b0;
      end
    end
    check("cont_lines_done", 32'(lines), 32'd16);
    cpu_req = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset in C_ACC aborts the store; the held request is re-granted afterwards.
    cpu_we = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'hA5A5_A5A5; cpu_req = 1'b1;
    @(posedge clk); #1;
    check("rstmid_we_before", 32'(ram_we), 32'h1);
    check("rstmid_addr_before", 32'(ram_addr), 32'h10);
    #2 rst = 1'b1;
    #1 check_all_zero("rstmid");
    repeat (2) @(posedge clk);
    #1;
    check("rstmid_no_ack", 32'(cpu_ack), 32'h0);
    check("rstmid_we_held", 32'(ram_we), 32'h0);
    @(negedge clk) rst = 1'b0;
    cpu_access(1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 10'h10, 32'h0, "rstmid_store");
    cpu_access(1'b0, 32'h0000_0040, 32'h0, 10'h10, 32'hA5A5_A5A5, "rstmid_load");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Arbiter and sequencer for the single-port 1024×32 data RAM. It shares the RAM between CPU load/store requests and a periodic display-scan engine that reads the first LINES words for the line display. RAM read latency is absorbed behind a request/acknowledge handshake, and the CPU and scan engine alternate fairly when both request.

## Interface
Parameters:
- LINES, 16: number of display lines scanned, at word addresses 0..LINES-1 (≤16).
- SCAN_DIV, 1000: clock cycles between scan refresh ticks (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request. Held high until cpu_ack.
- cpu_we  in  1  1 = store, 0 = load. Valid with cpu_req.
- cpu_addr  in  32  byte address from ALU. Word index is cpu_addr[11:2].
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- scan_en  in  1  enables periodic display refresh.
- scan_busy  out  1  a scan is pending or in progress.
- disp_line  out  4  line index of disp_data.
- disp_data  out  32  line contents, valid while disp_valid=1.
- disp_valid  out  1  one-cycle pulse per line read.
- ram_addr  out  10  RAM word address (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_wdata  out  32  RAM write data (registered).
- ram_rdata  in  32  RAM synchronous read data, valid one cycle after the RAM samples ram_addr.

## Operation
- The FSM has five states: IDLE, C_ACC, C_DONE, S_ACC, S_DONE.
- IDLE:
  - The CPU request is cpu_req && !cpu_ack. The scan request is scan_pending.
  - Only one request active: that requester is granted.
  - Both active: the requester not granted last time wins. The last_grant register resets to SCAN, so the CPU wins the first tie.
  - On a CPU grant: ram_addr<=cpu_addr[11:2], ram_we<=cpu_we, ram_wdata<=cpu_wdata, next state C_ACC.
  - On a scan grant: ram_addr<={6'b0,line_cnt}, ram_we<=0, next state S_ACC.
- C_ACC / S_ACC: ram_we<=0 and advance to the matching DONE state. The RAM samples during this cycle.
- C_DONE: cpu_rdata<=ram_rdata, cpu_ack<=1, next state IDLE.
  - For a store, cpu_rdata carries the RAM's read-during-write value and is don't-care.
- S_DONE: disp_data<=ram_rdata, disp_line<=line_cnt, disp_valid<=1, next state IDLE.
  - If line_cnt==LINES-1: line_cnt<=0 and scan_pending<=0.
  - Otherwise line_cnt<=line_cnt+1.
- cpu_ack and disp_valid are cleared in every cycle they are not being set.
- The refresh counter counts 0..SCAN_DIV-1 while scan_en=1 and wraps to 0.
  - At the wrap it sets scan_pending.
  - A wrap while scan_pending=1 is dropped and nothing is queued.
- scan_en=0:
  - The refresh counter is held at 0.
  - A scan already pending or in progress still completes all lines.
- scan_busy = scan_pending.
- Address arithmetic: cpu_addr[1:0] and cpu_addr[31:12] are ignored, so addresses wrap modulo 4 KiB. No alignment check is performed.

## Timing
- Reset (asynchronous, immediate) sets:
  - state=IDLE, last_grant=SCAN.
  - line_cnt=0, refresh counter=0, scan_pending=0.
  - All outputs 0: cpu_rdata, cpu_ack, disp_line, disp_data, disp_valid, ram_addr, ram_we, ram_wdata, scan_busy.
- CPU latency: request sampled in IDLE at edge E0. ram_* are driven after E0, with ram_we high for exactly one cycle. cpu_ack rises after E2 and falls after E3.
- One access completes every 3 cycles. Back-to-back CPU accesses achieve 1 access per 4 cycles, because IDLE ignores cpu_req during the cpu_ack cycle.
- One scan line takes 3 cycles. A full scan with no CPU traffic takes 3·LINES cycles from the IDLE grant to the last disp_valid.
- With CPU and scan contending, they alternate. CPU wait is bounded by one scan-line access (≤3 cycles extra).
- Reset asserted mid-access aborts the access immediately: ram_we=0, no ack. A CPU request still held after reset deasserts is re-granted from scratch.

## Test plan
- Store then load: store cpu_addr=0x0000_0010, wdata=0xDEADBEEF. Expect ram_addr=4 with ram_we high for 1 cycle, and cpu_ack 3 cycles after the request is sampled. A following load from 0x10 returns cpu_rdata=0xDEADBEEF with ack.
- Address wrap: a load from cpu_addr=0x0000_1008 drives ram_addr=2.
- Scan only: SCAN_DIV=20, scan_en=1, RAM word k=k+0x100. Expect 16 disp_valid pulses with disp_line 0..15 and disp_data 0x100..0x10F, 3 cycles apart. scan_busy falls after line 15.
- Contention: hold cpu_req continuously (reads) during a scan. Grants alternate CPU/scan. Each line arrives within 7 cycles of the previous one, and every CPU ack arrives within 7 cycles.
- Tick during scan: SCAN_DIV=10 (shorter than the 48-cycle scan). Pending ticks are dropped. After a scan completes, the next scan starts only at the next wrap.
- Reset mid-access: assert rst in C_ACC. Outputs go to 0 immediately. After release, the held cpu_req completes normally.
